// File: rtl/n_bit_register.sv
// N-bit load-enable register with synchronous clear and a valid flag.
// Outputs come straight from flops; async active-low reset.
module n_bit_register #(
  parameter int N = 8,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic         valid
);

  // clr has priority over en; no enable means hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= RESET_VALUE;
      valid <= 1'b0;
    end else if (clr) begin
      out   <= RESET_VALUE;
      valid <= 1'b0;
    end else if (en) begin
      out   <= in;
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_n_bit_register.sv
// Directed self-checking bench for the 16-bit n_bit_register.
// Inputs change on falling edges; outputs are checked there too.
module tb_n_bit_register;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [15:0] in;
  logic [15:0] out;
  logic        valid;

  int n_cmp;
  int n_fail;

  n_bit_register #(
    .N(16),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clr(clr),
    .in(in),
    .out(out),
    .valid(valid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, obs, obs, exp, exp);
    end
  endtask

  task automatic chk_both(input string tag,
                          input logic [15:0] eo,
                          input logic ev);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, ev});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    clr    = 1'b0;
    in     = 16'd2000;
    #2;
    chk_both("reset", 16'd0, 1'b0);
    #3 rst_n = 1'b1;

    // streaming loads, one per edge
    @(negedge clk);
    chk_both("ld2000", 16'd2000, 1'b1);
    in = 16'd2564;
    @(negedge clk);
    chk_both("ld2564", 16'd2564, 1'b1);
    in = 16'd5757;
    @(negedge clk);
    chk_both("ld5757", 16'd5757, 1'b1);
    in = 16'd1111;
    @(negedge clk);
    chk_both("ld1111", 16'd1111, 1'b1);
    in = 16'd2341;
    @(negedge clk);
    chk_both("ld2341", 16'd2341, 1'b1);
    in = 16'd5757;
    @(negedge clk);
    chk_both("reld5757", 16'd5757, 1'b1);

    // async reset mid-cycle, edges ignored while asserted
    rst_n = 1'b0;
    #1;
    chk_both("arst_now", 16'd0, 1'b0);
    in = 16'd4444;
    @(negedge clk);
    chk_both("arst_hold1", 16'd0, 1'b0);
    in = 16'd1234;
    @(negedge clk);
    chk_both("arst_hold2", 16'd0, 1'b0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk_both("post_rst", 16'd1234, 1'b1);

    // hold with en=0
    en = 1'b0;
    in = 16'd4321;
    @(negedge clk);
    chk_both("hold1", 16'd1234, 1'b1);
    @(negedge clk);
    chk_both("hold2", 16'd1234, 1'b1);
    @(negedge clk);
    chk_both("hold3", 16'd1234, 1'b1);

    // clear overrides enable
    en = 1'b1;
    in = 16'd1111;
    @(negedge clk);
    chk_both("pre_clr", 16'd1111, 1'b1);
    clr = 1'b1;
    in  = 16'd9999;
    @(negedge clk);
    chk_both("clr", 16'd0, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    chk_both("after_clr", 16'd9999, 1'b1);

    // extreme patterns
    in = 16'hFFFF;
    @(negedge clk);
    chk_both("ones", 16'hFFFF, 1'b1);
    in = 16'h0000;
    @(negedge clk);
    chk_both("zeros", 16'h0000, 1'b1);
    in = 16'hA5A5;
    @(negedge clk);
    chk_both("a5a5", 16'hA5A5, 1'b1);

    // input and control wiggle between edges
    #2 in = 16'h0001;
    #2 in = 16'hFFFF;
    #2 clr = 1'b1;
    #1 clr = 1'b0;
    #1;
    chk_both("wiggle", 16'hA5A5, 1'b1);
    en = 1'b0;
    in = 16'h1357;
    @(negedge clk);
    chk_both("wiggle_edge", 16'hA5A5, 1'b1);
    #3 clr = 1'b1;
    #3 clr = 1'b0;
    @(negedge clk);
    chk_both("clr_glitch", 16'hA5A5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/n_bit_register.md
N_BIT_REGISTER -- requirements
Module: n_bit_register

Interface
REQ-001 Parameter N, default 8: data width in bits; legal range 1..64; the 16-bit instance is the primary configuration.
REQ-002 Parameter RESET_VALUE, default 0 (N bits): value loaded into out on reset.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge only.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  load enable; 1 = capture in on the next rising clk edge.
REQ-006 clr  input  1  synchronous clear to RESET_VALUE; overrides en.
REQ-007 in  input  N  parallel data input, unsigned.
REQ-008 out  output  N  registered data output.
REQ-009 valid  output  1  1 = out holds data captured from in since the last reset or clear.

Function
REQ-010 out and valid SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-011 On a rising clk edge with rst_n=1, clr=0 and en=1, the block SHALL set out=in (sampled at that edge) and valid=1.
REQ-012 Load latency SHALL be one clock: a value applied to in before edge k SHALL appear on out after edge k.
REQ-013 On a rising clk edge with rst_n=1, clr=0 and en=0, the block SHALL hold out and valid unchanged.
REQ-014 On a rising clk edge with rst_n=1 and clr=1, the block SHALL set out=RESET_VALUE and valid=0, regardless of en or in.
REQ-015 Changes on in, en or clr between rising edges SHALL have no effect on out or valid.
REQ-016 The block SHALL store all N bits unmodified: no sign extension, no truncation, and no arithmetic on the data.
REQ-017 Back-to-back loads on consecutive edges SHALL each be captured, giving one new value per cycle with no bubbles.
REQ-018 The input values all-zeros and all-ones (for example 16'hFFFF) SHALL be stored exactly.

Reset
REQ-019 When rst_n=0, the block SHALL set out=RESET_VALUE and valid=0 immediately, without waiting for a clk edge.
REQ-020 While rst_n=0, the block SHALL ignore clk edges and hold the reset values.
REQ-021 Reset asserted in the middle of a sequence of loads SHALL discard the stored data, with no partial update.
REQ-022 After rst_n is released (0->1), the first rising clk edge SHALL be processed normally per REQ-011..REQ-014.
REQ-023 Release of rst_n SHALL be synchronized externally so that deassertion meets recovery and removal timing; the block does not add a reset synchronizer.

Verification
REQ-024 N=16, clk period 20, first rising edge at t=10; hold en=1, clr=0; apply in=2000, 2564, 5757, 1111, 2341 every 20 time units starting at t=0 -> out reads 2000, 2564, 5757, 1111, 2341 after edges at t=10, 30, 50, 70, 90; valid=1 from t=10.
REQ-025 Assert rst_n=0 at mid-cycle after out=5757 -> out=0 and valid=0 at once, before the next edge; both remain 0 while rst_n=0 even with en=1 and in toggling.
REQ-026 Load in=1234, then en=0 while in=4321 for 3 edges -> out stays 1234 and valid stays 1.
REQ-027 out=1111, then clr=1 and en=1 with in=9999 -> out=0 and valid=0 after that edge; clr=0 on the next edge -> out=9999.
REQ-028 Load in=16'hFFFF, then in=16'h0000, then in=16'hA5A5 on successive edges -> each value appears exactly on out one edge later.
REQ-029 Wiggle in between edges with no edge occurring -> out does not change.
